id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Parametrised ID/EX pipeline stage for the MIPS pipeline, replacing the fixed free-running ID/EX register.
- Carries PC, PC+4, both register read values, the sign-extended immediate, the instruction and decode control bits from ID to EX.
- Adds a valid/ready handshake with an optional skid buffer, flush (bubble insertion), correct rs/rt/rd/shamt extraction and a saturating stall counter.

Parameters:
- DATA_W, 32, width of PC, read-data, immediate and instruction fields.
- REG_AW, 5, register-address field width (rs/rt/rd/shamt).
- CTRL_W, 8, width of the opaque decode control bundle.
- SKID_EN, 1, 1 = two-entry stage with registered in_ready; 0 = single entry, in_ready combinational.
- CNT_W, 16, stall counter width.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, 1, ID presents a valid instruction.
- in_ready, out, 1, stage can accept this cycle.
- cur_pc_in, next_pc_in, rd1_in, rd2_in, imm_in, instr_in, in, DATA_W each, ID payload.
- ctrl_in, in, CTRL_W, decode control bundle.
- flush, in, 1, kill all held and incoming instructions.
- out_valid, out, 1, EX payload valid.
- out_ready, in, 1, EX accepts this cycle.
- cur_pc_out, next_pc_out, rd1_out, rd2_out, imm_out, instr_out, out, DATA_W each, registered payload.
- ctrl_out, out, CTRL_W, registered control.
- rs_out, rt_out, rd_out, shamt_out, out, REG_AW each, instr[25:21], [20:16], [15:11], [10:6] of the held instruction.
- stall_cnt, out, CNT_W, cycles with out_valid=1 and out_ready=0.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). On a clk edge with rst_n=0:
  - out_valid=0; skid valid=0; in_ready=1.
  - All payload outputs, field outputs and stall_cnt = 0.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Field outputs are registered alongside instr_out (no combinational path from instr_in).
- SKID_EN=1 states:
  - EMPTY (out_valid=0): accept -> MAIN.
  - MAIN: accept with no release -> FULL, payload into skid. Accept with release -> MAIN, new payload into main. Release with no accept -> EMPTY.
  - FULL: in_ready=0. Release -> MAIN, skid moves to main.
  - in_ready = !skid_valid, registered. No combinational path from out_ready to in_ready.
- SKID_EN=0: single entry; in_ready = !out_valid | out_ready. Skid logic absent.
- Hold: when out_valid=1 and out_ready=0, every output stays bit-identical.
- Flush has priority over all other events. At the next edge: out_valid=0, skid cleared, in_ready=1. The in-cycle accept is discarded. Payload registers may keep stale data, but out_valid=0 qualifies them.
- Reset mid-operation follows the reset values regardless of flush or handshake inputs.
- stall_cnt increments on each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1. Flush does not clear it; only reset does.
- Instruction order is preserved: main drains before skid.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and REG_AW defaults.
  - Field bit positions: RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO.
  - Packed struct id_ex_payload_t (PCs, read data, imm, instr, ctrl).
  - Stage state enum {EMPTY, MAIN, FULL}.
- Natural sub-module pipe_skid_buf: generic two-entry valid/ready buffer over a packed payload, parametrised by width and SKID_EN. It is reused later for the EX/MEM and MEM/WB stages. Field extraction and stall_cnt stay in id_ex_stage.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, stall_cnt=0, all outputs 0.
- Single transfer with out_ready=1: send instr_in=32'h014B4820 (add $9,$10,$11) -> one cycle later out_valid=1, rs=10, rt=11, rd=9, shamt=0, and the payload matches.
- Back-pressure (SKID_EN=1): send A, B, C back-to-back with out_ready=0 -> in_ready drops after B. C is held until it is accepted. Raise out_ready -> output order A, B, C. stall_cnt equals the count of stalled cycles (e.g. 3). Outputs stay stable while stalled.
- Flush: with FULL state, assert flush together with in_valid=1 for D -> next cycle out_valid=0, in_ready=1, and D never appears at the output.
- Saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15.
- SKID_EN=0, out_ready held at 1: stream 100 random instructions -> in_ready=1 every cycle, zero-bubble throughput, output matches the input sequence delayed by 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, instruction field positions,
// the ID/EX payload layout and the pipeline-stage occupancy states.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CTRL_W = 8;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] cur_pc;
    logic [DEF_DATA_W-1:0] next_pc;
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_CTRL_W-1:0] ctrl;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register over a flat payload; with SKID_EN=1 a second
// entry absorbs one transfer so in_ready can come straight from a flop.
module pipe_skid_buf #(
  parameter int W       = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import mips_pkg::*;

  stage_state_e state_r;
  stage_state_e state_nx_s;
  logic [W-1:0] main_r;
  logic [W-1:0] skid_data_s;
  logic         accept_s;
  logic         release_s;
  logic         load_in_s;
  logic         load_skid_s;
  logic         pop_skid_s;

  assign accept_s  = in_valid & in_ready;
  assign release_s = out_valid & out_ready;
  assign out_valid = (state_r != EMPTY);
  assign out_data  = main_r;

  // Occupancy next-state and datapath steering; flush overrides every handshake.
  always_comb begin
    state_nx_s  = state_r;
    load_in_s   = 1'b0;
    load_skid_s = 1'b0;
    pop_skid_s  = 1'b0;
    if (flush) begin
      state_nx_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nx_s = MAIN;
            load_in_s  = 1'b1;
          end else begin
            state_nx_s = EMPTY;
          end
        end
        MAIN: begin
          if (accept_s && release_s) begin
            load_in_s = 1'b1;
          end else if (accept_s) begin
            state_nx_s  = FULL;
            load_skid_s = 1'b1;
          end else if (release_s) begin
            state_nx_s = EMPTY;
          end else begin
            state_nx_s = MAIN;
          end
        end
        FULL: begin
          if (release_s) begin
            state_nx_s = MAIN;
            pop_skid_s = 1'b1;
          end else begin
            state_nx_s = FULL;
          end
        end
        default: state_nx_s = EMPTY;
      endcase
    end
  end

  // State and output entry registers; main always holds the oldest instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      main_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      if (load_in_s) begin
        main_r <= in_data;
      end else if (pop_skid_s) begin
        main_r <= skid_data_s;
      end
    end
  end

  if (SKID_EN) begin : g_skid
    logic [W-1:0] skid_r;
    logic         in_ready_r;

    // Skid entry plus registered ready, derived from next occupancy so out_ready never reaches in_ready.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        skid_r     <= '0;
        in_ready_r <= 1'b1;
      end else begin
        in_ready_r <= (state_nx_s != FULL);
        if (load_skid_s) begin
          skid_r <= in_data;
        end
      end
    end

    assign skid_data_s = skid_r;
    assign in_ready    = in_ready_r;
  end else begin : g_no_skid
    assign skid_data_s = '0;
    assign in_ready    = ~out_valid | out_ready;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: carries the decoded instruction to EX through a valid/ready
// buffer, exposes register fields of the held instruction and counts stall cycles.
module id_ex_stage #(
  parameter int DATA_W  = mips_pkg::DEF_DATA_W,
  parameter int REG_AW  = mips_pkg::DEF_REG_AW,
  parameter int CTRL_W  = mips_pkg::DEF_CTRL_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cur_pc_in,
  input  logic [DATA_W-1:0] next_pc_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] cur_pc_out,
  output logic [DATA_W-1:0] next_pc_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [REG_AW-1:0] rs_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [REG_AW-1:0] shamt_out,
  output logic [CNT_W-1:0]  stall_cnt
);
  import mips_pkg::*;

  // Same layout as id_ex_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] cur_pc;
    logic [DATA_W-1:0] next_pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] instr;
    logic [CTRL_W-1:0] ctrl;
  } stage_payload_t;

  localparam int PAY_W = $bits(stage_payload_t);

  stage_payload_t   in_pay_s;
  stage_payload_t   out_pay_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign in_pay_s = '{cur_pc: cur_pc_in, next_pc: next_pc_in, rd1: rd1_in, rd2: rd2_in,
                      imm: imm_in, instr: instr_in, ctrl: ctrl_in};

  pipe_skid_buf #(
    .W       (PAY_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay_s)
  );

  assign cur_pc_out  = out_pay_s.cur_pc;
  assign next_pc_out = out_pay_s.next_pc;
  assign rd1_out     = out_pay_s.rd1;
  assign rd2_out     = out_pay_s.rd2;
  assign imm_out     = out_pay_s.imm;
  assign instr_out   = out_pay_s.instr;
  assign ctrl_out    = out_pay_s.ctrl;

  // Fields are slices of the registered instruction, so they move with instr_out.
  assign rs_out    = out_pay_s.instr[RS_HI:RS_LO];
  assign rt_out    = out_pay_s.instr[RT_HI:RT_LO];
  assign rd_out    = out_pay_s.instr[RD_HI:RD_LO];
  assign shamt_out = out_pay_s.instr[SH_HI:SH_LO];

  // Saturating count of cycles EX refused a valid instruction; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: three instances (skid, skid with 4-bit counter, no skid) share
// one stimulus stream and are compared every cycle against a queue-based model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [7:0]  ctrl;
  } pay_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, flush;
  pay_t din;

  logic        ov [3];
  logic        ir [3];
  logic [31:0] o_pc [3], o_npc [3], o_rd1 [3], o_rd2 [3], o_imm [3], o_ins [3];
  logic [7:0]  o_ctl [3];
  logic [4:0]  o_rs [3], o_rt [3], o_rd [3], o_sh [3];
  logic [15:0] sc_a, sc_c;
  logic [3:0]  sc_b;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.SKID_EN(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .cur_pc_in(din.cur_pc), .next_pc_in(din.next_pc), .rd1_in(din.rd1), .rd2_in(din.rd2),
    .imm_in(din.imm), .instr_in(din.instr), .ctrl_in(din.ctrl), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready),
    .cur_pc_out(o_pc[0]), .next_pc_out(o_npc[0]), .rd1_out(o_rd1[0]), .rd2_out(o_rd2[0]),
    .imm_out(o_imm[0]), .instr_out(o_ins[0]), .ctrl_out(o_ctl[0]),
    .rs_out(o_rs[0]), .rt_out(o_rt[0]), .rd_out(o_rd[0]), .shamt_out(o_sh[0]),
    .stall_cnt(sc_a));

  id_ex_stage #(.SKID_EN(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .cur_pc_in(din.cur_pc), .next_pc_in(din.next_pc), .rd1_in(din.rd1), .rd2_in(din.rd2),
    .imm_in(din.imm), .instr_in(din.instr), .ctrl_in(din.ctrl), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready),
    .cur_pc_out(o_pc[1]), .next_pc_out(o_npc[1]), .rd1_out(o_rd1[1]), .rd2_out(o_rd2[1]),
    .imm_out(o_imm[1]), .instr_out(o_ins[1]), .ctrl_out(o_ctl[1]),
    .rs_out(o_rs[1]), .rt_out(o_rt[1]), .rd_out(o_rd[1]), .shamt_out(o_sh[1]),
    .stall_cnt(sc_b));

  id_ex_stage #(.SKID_EN(1'b0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .cur_pc_in(din.cur_pc), .next_pc_in(din.next_pc), .rd1_in(din.rd1), .rd2_in(din.rd2),
    .imm_in(din.imm), .instr_in(din.instr), .ctrl_in(din.ctrl), .flush(flush),
    .out_valid(ov[2]), .out_ready(out_ready),
    .cur_pc_out(o_pc[2]), .next_pc_out(o_npc[2]), .rd1_out(o_rd1[2]), .rd2_out(o_rd2[2]),
    .imm_out(o_imm[2]), .instr_out(o_ins[2]), .ctrl_out(o_ctl[2]),
    .rs_out(o_rs[2]), .rt_out(o_rt[2]), .rd_out(o_rd[2]), .shamt_out(o_sh[2]),
    .stall_cnt(sc_c));

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  pay_t        mq [3][$];
  int unsigned m_cnt  [3];
  bit          m_rdy  [3];
  bit          m_zero [3];
  bit          mdl_acc, mdl_rel;

  function automatic int unsigned cnt_max(input int i);
    return (i == 1) ? 32'd15 : 32'd65535;
  endfunction

  function automatic bit exp_rdy(input int i);
    if (i == 2) return (mq[i].size() == 0) || out_ready;
    return m_rdy[i];
  endfunction

  function automatic logic [15:0] act_sc(input int i);
    if (i == 0) return sc_a;
    if (i == 1) return {12'd0, sc_b};
    return sc_c;
  endfunction

  task automatic chk(input int i, input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d) at %0t: got 0x%0h, want 0x%0h", nm, i, $time, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rdy[i] = 1'b1; m_zero[i] = 1'b1;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          mq[i].delete(); m_cnt[i] = 0; m_rdy[i] = 1'b1; m_zero[i] = 1'b1;
        end else begin
          mdl_acc = in_valid && exp_rdy(i);
          mdl_rel = (mq[i].size() > 0) && out_ready;
          if ((mq[i].size() > 0) && !out_ready && (m_cnt[i] < cnt_max(i))) m_cnt[i]++;
          if (flush) begin
            mq[i].delete();
          end else begin
            if (mdl_rel) void'(mq[i].pop_front());
            if (mdl_acc) begin
              mq[i].push_back(din);
              m_zero[i] = 1'b0;
            end
          end
          m_rdy[i] = (mq[i].size() < 2);
        end
      end
    end
  end

  pay_t cmp_exp, cmp_act;

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk(i, "out_valid", ov[i], mq[i].size() > 0);
      chk(i, "in_ready", ir[i], exp_rdy(i));
      chk(i, "stall_cnt", act_sc(i), m_cnt[i]);
      if ((mq[i].size() > 0) || m_zero[i]) begin
        cmp_exp = (mq[i].size() > 0) ? mq[i][0] : '0;
        cmp_act = {o_pc[i], o_npc[i], o_rd1[i], o_rd2[i], o_imm[i], o_ins[i], o_ctl[i]};
        chk(i, "payload", cmp_act, cmp_exp);
        chk(i, "rs", o_rs[i], cmp_exp.instr[25:21]);
        chk(i, "rt", o_rt[i], cmp_exp.instr[20:16]);
        chk(i, "rd", o_rd[i], cmp_exp.instr[15:11]);
        chk(i, "shamt", o_sh[i], cmp_exp.instr[10:6]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_pay();
    din.cur_pc  = $urandom;
    din.next_pc = $urandom;
    din.rd1     = $urandom;
    din.rd2     = $urandom;
    din.imm     = $urandom;
    din.instr   = $urandom;
    din.ctrl    = 8'($urandom_range(0, 255));
  endtask

  logic [31:0] a_ins, b_ins, c_ins;
  int          n_wait, n_bub;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    rand_pay();
    step(); step();
    chk(0, "rst_out_valid", ov[0], 1'b0);
    chk(0, "rst_in_ready", ir[0], 1'b1);
    chk(0, "rst_stall_cnt", sc_a, 16'd0);
    chk(0, "rst_instr_out", o_ins[0], 32'd0);

    // add $9,$10,$11 through an empty stage
    rst_n = 1'b1; out_ready = 1'b1; rand_pay(); din.instr = 32'h014B4820;
    step();
    chk(0, "add_out_valid", ov[0], 1'b1);
    chk(0, "add_instr", o_ins[0], 32'h014B4820);
    chk(0, "add_rs", o_rs[0], 5'd10);
    chk(0, "add_rt", o_rt[0], 5'd11);
    chk(0, "add_rd", o_rd[0], 5'd9);
    chk(0, "add_shamt", o_sh[0], 5'd0);
    in_valid = 1'b0;
    step();

    // back-pressure: A, B, C with EX stalled
    out_ready = 1'b0; in_valid = 1'b1;
    rand_pay(); a_ins = din.instr; step();
    rand_pay(); b_ins = din.instr; step();
    chk(0, "bp_in_ready_drop", ir[0], 1'b0);
    rand_pay(); c_ins = din.instr; step(); step();
    chk(0, "bp_stall_cnt", sc_a, 16'd3);
    chk(0, "bp_hold_a", o_ins[0], a_ins);
    out_ready = 1'b1;
    step();
    chk(0, "bp_order_b", o_ins[0], b_ins);
    n_wait = 0;
    while (!ir[0] && n_wait < 8) begin
      step();
      n_wait++;
    end
    chk(0, "bp_c_ready", ir[0], 1'b1);
    step();
    in_valid = 1'b0;
    chk(0, "bp_order_c", o_ins[0], c_ins);
    step(); step();

    // flush while FULL, with D offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    rand_pay(); step();
    rand_pay(); step();
    chk(0, "fl_full", ir[0], 1'b0);
    rand_pay(); flush = 1'b1;
    step();
    chk(0, "fl_out_valid", ov[0], 1'b0);
    chk(0, "fl_in_ready", ir[0], 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk(0, "fl_no_d", ov[0], 1'b0);
    end

    // saturation of the 4-bit counter
    out_ready = 1'b0; in_valid = 1'b1; rand_pay();
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk(1, "sat_stall_cnt", {12'd0, sc_b}, 16'd15);
    out_ready = 1'b1;
    step(); step();

    // zero-bubble streaming through the single-entry instance
    n_bub = 0; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rand_pay();
      step();
      if (!ir[2]) n_bub++;
      if (!ov[2]) n_bub++;
    end
    chk(2, "stream_bubbles", n_bub, 0);
    in_valid = 1'b0;
    step();

    // random traffic with occasional flush and mid-run reset
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 63) != 0);
      rand_pay();
      step();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
